// File: rtl/el2_dec_gpr_dbg_access.sv
// ---------------------------------------------------------------------------
// el2_dec_gpr_dbg_access
//
// Debug abstract-command engine for the integer GPR file. It accepts one
// read or write command at a time from the debug module. It drives the GPR
// read address and samples the returned data. It also owns one GPR write
// port, which it shares with pipeline writeback: the pipeline has priority
// whenever wb_busy is high.
//
// Handshakes: a command transfers on a cycle where dbg_cmd_valid and
// dbg_cmd_ready are both high. A response transfers on a cycle where
// dbg_rsp_valid and dbg_rsp_ready are both high. While dbg_rsp_valid is high,
// dbg_rsp_data and dbg_rsp_fail hold steady until that transfer happens.
//
// Ports:
//   clk, rst_l                     clock, asynchronous active-low reset
//   dbg_cmd_valid/ready            command handshake
//   dbg_cmd_write/addr/wrdata      command payload (1 = write)
//   dbg_rsp_valid/ready            response handshake
//   dbg_rsp_fail/data              response payload
//   dbg_halted                     core halted; commands fail otherwise
//   wb_busy                        pipeline owns the write port this cycle
//   gpr_raddr, gpr_rdata           GPR read port (rdata combinational)
//   gpr_wen, gpr_waddr, gpr_wdata  shared GPR write port
// ---------------------------------------------------------------------------
module el2_dec_gpr_dbg_access #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        dbg_cmd_valid,
    output logic        dbg_cmd_ready,
    input  logic        dbg_cmd_write,
    input  logic [4:0]  dbg_cmd_addr,
    input  logic [31:0] dbg_cmd_wrdata,
    output logic        dbg_rsp_valid,
    input  logic        dbg_rsp_ready,
    output logic        dbg_rsp_fail,
    output logic [31:0] dbg_rsp_data,
    input  logic        dbg_halted,
    input  logic        wb_busy,
    output logic [4:0]  gpr_raddr,
    input  logic [31:0] gpr_rdata,
    output logic        gpr_wen,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    logic [4:0]  addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  wait_cnt;
    logic        cmd_accept;
    logic        last_wait;

    assign dbg_cmd_ready = (state == IDLE);
    assign dbg_rsp_valid = (state == RESP);
    assign cmd_accept    = dbg_cmd_valid & dbg_cmd_ready;

    // The next busy cycle is the one that makes the wait count reach TIMEOUT.
    assign last_wait = (wait_cnt == 8'(TIMEOUT - 1));

    // The latched command drives both GPR ports. The registers reset to zero.
    assign gpr_raddr = addr_q;
    assign gpr_waddr = addr_q;
    assign gpr_wdata = wdata_q;

    // The write strobe comes from the WRITE state and lasts one cycle,
    // because the state leaves WRITE on the same edge. A halt drop blocks it,
    // and x0 is never written.
    assign gpr_wen = (state == WRITE) & dbg_halted & ~wb_busy & (addr_q != 5'd0);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state        <= IDLE;
            addr_q       <= 5'd0;
            wdata_q      <= 32'd0;
            wait_cnt     <= 8'd0;
            dbg_rsp_fail <= 1'b0;
            dbg_rsp_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_accept) begin
                        addr_q   <= dbg_cmd_addr;
                        wdata_q  <= dbg_cmd_wrdata;
                        wait_cnt <= 8'd0;
                        if (!dbg_halted) begin
                            dbg_rsp_fail <= 1'b1;
                            dbg_rsp_data <= 32'd0;
                            state        <= RESP;
                        end else if (dbg_cmd_write) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end

                READ: begin
                    if (!dbg_halted) begin
                        dbg_rsp_fail <= 1'b1;
                        dbg_rsp_data <= 32'd0;
                    end else begin
                        dbg_rsp_fail <= 1'b0;
                        // x0 reads as zero whatever the file returns.
                        dbg_rsp_data <= (addr_q == 5'd0) ? 32'd0 : gpr_rdata;
                    end
                    state <= RESP;
                end

                WRITE: begin
                    // A halt drop has priority over contention and timeout.
                    if (!dbg_halted) begin
                        dbg_rsp_fail <= 1'b1;
                        dbg_rsp_data <= 32'd0;
                        state        <= RESP;
                    end else if (!wb_busy) begin
                        dbg_rsp_fail <= 1'b0;
                        dbg_rsp_data <= 32'd0;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (last_wait) begin
                            dbg_rsp_fail <= 1'b1;
                            dbg_rsp_data <= 32'd0;
                            state        <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (dbg_rsp_ready) begin
                        dbg_rsp_fail <= 1'b0;
                        dbg_rsp_data <= 32'd0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_el2_dec_gpr_dbg_access.sv
// ---------------------------------------------------------------------------
// Testbench for el2_dec_gpr_dbg_access. The first part is a table of directed
// command vectors with hand-computed latency and response values. After the
// table come hand-written sequences: response back-pressure, and reset
// mid-write and mid-response. A small GPR file model answers reads and
// absorbs writes. Unwritten entries hold 0xA5A5_00nn, and x0 returns all
// ones so that a missing x0 mask shows up.
// ---------------------------------------------------------------------------
module tb_el2_dec_gpr_dbg_access;

    logic        clk;
    logic        rst_l;
    logic        dbg_cmd_valid;
    logic        dbg_cmd_ready;
    logic        dbg_cmd_write;
    logic [4:0]  dbg_cmd_addr;
    logic [31:0] dbg_cmd_wrdata;
    logic        dbg_rsp_valid;
    logic        dbg_rsp_ready;
    logic        dbg_rsp_fail;
    logic [31:0] dbg_rsp_data;
    logic        dbg_halted;
    logic        wb_busy;
    logic [4:0]  gpr_raddr;
    logic [31:0] gpr_rdata;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;

    int total = 0;
    int bad   = 0;

    el2_dec_gpr_dbg_access #(.TIMEOUT(15)) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .dbg_cmd_valid  (dbg_cmd_valid),
        .dbg_cmd_ready  (dbg_cmd_ready),
        .dbg_cmd_write  (dbg_cmd_write),
        .dbg_cmd_addr   (dbg_cmd_addr),
        .dbg_cmd_wrdata (dbg_cmd_wrdata),
        .dbg_rsp_valid  (dbg_rsp_valid),
        .dbg_rsp_ready  (dbg_rsp_ready),
        .dbg_rsp_fail   (dbg_rsp_fail),
        .dbg_rsp_data   (dbg_rsp_data),
        .dbg_halted     (dbg_halted),
        .wb_busy        (wb_busy),
        .gpr_raddr      (gpr_raddr),
        .gpr_rdata      (gpr_rdata),
        .gpr_wen        (gpr_wen),
        .gpr_waddr      (gpr_waddr),
        .gpr_wdata      (gpr_wdata)
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- GPR file model ----
    logic [31:0] mem [32];
    logic [31:0] written;
    logic        model_clr;

    always @(posedge clk) begin
        if (model_clr) begin
            written <= 32'd0;
        end else if (gpr_wen) begin
            mem[gpr_waddr]     <= gpr_wdata;
            written[gpr_waddr] <= 1'b1;
        end
    end

    always_comb begin
        gpr_rdata = 32'hA5A5_0000 | {27'd0, gpr_raddr};
        if (gpr_raddr == 5'd0) gpr_rdata = 32'hFFFF_FFFF;
        if (written[gpr_raddr]) gpr_rdata = mem[gpr_raddr];
    end

    // ---- checking ----
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".cmd_ready"}, 32'(dbg_cmd_ready), 32'd1);
        check({tag, ".rsp_valid"}, 32'(dbg_rsp_valid), 32'd0);
        check({tag, ".rsp_fail"},  32'(dbg_rsp_fail),  32'd0);
        check({tag, ".rsp_data"},  dbg_rsp_data,       32'd0);
        check({tag, ".gpr_wen"},   32'(gpr_wen),       32'd0);
        check({tag, ".raddr"},     32'(gpr_raddr),     32'd0);
        check({tag, ".waddr"},     32'(gpr_waddr),     32'd0);
        check({tag, ".wdata"},     gpr_wdata,          32'd0);
    endtask

    // busy: number of busy cycles after acceptance. drop: the cycle (after
    // acceptance) from which halted goes low, 0 = never. exp_lat: the cycle
    // in which rsp_valid first rises. exp_wen_at: the write cycle, 0 = none.
    typedef struct {
        logic        halted;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          busy;
        int          drop;
        logic        exp_fail;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_wen_at;
    } vec_t;

    // Called at posedge+1. Returns at posedge+1, with the engine back in IDLE.
    task automatic run_vec(input int idx, input vec_t v);
        int          wen_cnt  = 0;
        int          wen_at   = 0;
        int          rsp_at   = 0;
        logic [4:0]  wa       = '0;
        logic [31:0] wd       = '0;
        logic        busy_wen = 1'b0;
        logic        rsp_fail = 1'b0;
        logic [31:0] rsp_data = '0;
        logic        rdy_resp = 1'b0;
        string       tag;
        tag = $sformatf("vec%0d", idx);

        dbg_halted     = v.halted;
        dbg_cmd_valid  = 1'b1;
        dbg_cmd_write  = v.wr;
        dbg_cmd_addr   = v.addr;
        dbg_cmd_wrdata = v.wdata;
        dbg_rsp_ready  = 1'b1;
        wb_busy        = 1'b0;
        @(negedge clk);
        check({tag, ".cmd_ready"}, 32'(dbg_cmd_ready), 32'd1);
        @(posedge clk); #1;
        dbg_cmd_valid = 1'b0;

        for (int k = 1; k <= 40; k++) begin
            wb_busy = (k <= v.busy);
            if (v.drop != 0 && k >= v.drop) dbg_halted = 1'b0;
            @(negedge clk);
            if (gpr_wen) begin
                wen_cnt++;
                if (wen_at == 0) wen_at = k;
                wa = gpr_waddr;
                wd = gpr_wdata;
                if (wb_busy) busy_wen = 1'b1;
            end
            if (dbg_rsp_valid) begin
                rsp_at   = k;
                rsp_fail = dbg_rsp_fail;
                rsp_data = dbg_rsp_data;
                rdy_resp = dbg_cmd_ready;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        wb_busy    = 1'b0;
        dbg_halted = 1'b1;

        check({tag, ".rsp_latency"}, 32'(rsp_at), 32'(v.exp_lat));
        check({tag, ".rsp_fail"},    32'(rsp_fail), 32'(v.exp_fail));
        check({tag, ".rsp_data"},    rsp_data, v.exp_data);
        check({tag, ".cmd_ready_in_resp"}, 32'(rdy_resp), 32'd0);
        check({tag, ".wen_count"}, 32'(wen_cnt), (v.exp_wen_at != 0) ? 32'd1 : 32'd0);
        check({tag, ".wen_while_busy"}, 32'(busy_wen), 32'd0);
        if (v.exp_wen_at != 0) begin
            check({tag, ".wen_cycle"}, 32'(wen_at), 32'(v.exp_wen_at));
            check({tag, ".waddr"},     32'(wa), 32'(v.addr));
            check({tag, ".wdata"},     wd, v.wdata);
        end
    endtask

    vec_t vecs[17];

    initial begin
        logic wen_seen;

        vecs[0]  = '{1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF, 0,  0, 1'b0, 32'h0000_0000, 2,  1};
        vecs[1]  = '{1'b1, 1'b0, 5'd5,  32'h0,         0,  0, 1'b0, 32'hDEAD_BEEF, 2,  0};
        vecs[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,         0,  0, 1'b0, 32'h0000_0000, 2,  0};
        vecs[3]  = '{1'b1, 1'b1, 5'd0,  32'h0000_1234, 0,  0, 1'b0, 32'h0000_0000, 2,  0};
        vecs[4]  = '{1'b0, 1'b1, 5'd9,  32'h9999_9999, 0,  0, 1'b1, 32'h0000_0000, 1,  0};
        vecs[5]  = '{1'b0, 1'b0, 5'd5,  32'h0,         0,  0, 1'b1, 32'h0000_0000, 1,  0};
        vecs[6]  = '{1'b1, 1'b1, 5'd7,  32'h0000_0077, 3,  0, 1'b0, 32'h0000_0000, 5,  4};
        vecs[7]  = '{1'b1, 1'b0, 5'd7,  32'h0,         0,  0, 1'b0, 32'h0000_0077, 2,  0};
        vecs[8]  = '{1'b1, 1'b1, 5'd8,  32'h8888_8888, 99, 0, 1'b1, 32'h0000_0000, 16, 0};
        vecs[9]  = '{1'b1, 1'b0, 5'd8,  32'h0,         0,  0, 1'b0, 32'hA5A5_0008, 2,  0};
        vecs[10] = '{1'b1, 1'b1, 5'd31, 32'hCAFE_F00D, 14, 0, 1'b0, 32'h0000_0000, 16, 15};
        vecs[11] = '{1'b1, 1'b0, 5'd31, 32'h0,         0,  0, 1'b0, 32'hCAFE_F00D, 2,  0};
        vecs[12] = '{1'b1, 1'b0, 5'd1,  32'h0,         2,  0, 1'b0, 32'hA5A5_0001, 2,  0};
        vecs[13] = '{1'b1, 1'b1, 5'd10, 32'h1010_1010, 99, 3, 1'b1, 32'h0000_0000, 4,  0};
        vecs[14] = '{1'b1, 1'b0, 5'd3,  32'h0,         0,  1, 1'b1, 32'h0000_0000, 2,  0};
        vecs[15] = '{1'b1, 1'b1, 5'd11, 32'h1111_1111, 0,  1, 1'b1, 32'h0000_0000, 2,  0};
        vecs[16] = '{1'b1, 1'b0, 5'd11, 32'h0,         0,  0, 1'b0, 32'hA5A5_000B, 2,  0};

        // ---- reset ----
        rst_l          = 1'b0;
        model_clr      = 1'b1;
        dbg_cmd_valid  = 1'b0;
        dbg_cmd_write  = 1'b0;
        dbg_cmd_addr   = 5'd0;
        dbg_cmd_wrdata = 32'd0;
        dbg_rsp_ready  = 1'b1;
        dbg_halted     = 1'b1;
        wb_busy        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_l     = 1'b1;
        model_clr = 1'b0;
        @(posedge clk); #1;

        // ---- table ----
        foreach (vecs[i]) run_vec(i, vecs[i]);

        // ---- read x3 with 4 cycles of response back-pressure ----
        dbg_cmd_valid = 1'b1;
        dbg_cmd_write = 1'b0;
        dbg_cmd_addr  = 5'd3;
        dbg_rsp_ready = 1'b0;
        @(posedge clk); #1;
        dbg_cmd_valid = 1'b0;
        @(negedge clk);
        check("stall.valid_t1", 32'(dbg_rsp_valid), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            // A write attempted during RESP must be ignored.
            dbg_cmd_valid  = 1'b1;
            dbg_cmd_write  = 1'b1;
            dbg_cmd_addr   = 5'd4;
            dbg_cmd_wrdata = 32'h4444_4444;
            @(negedge clk);
            check($sformatf("stall%0d.rsp_valid", i), 32'(dbg_rsp_valid), 32'd1);
            check($sformatf("stall%0d.rsp_data", i),  dbg_rsp_data, 32'hA5A5_0003);
            check($sformatf("stall%0d.rsp_fail", i),  32'(dbg_rsp_fail), 32'd0);
            check($sformatf("stall%0d.cmd_ready", i), 32'(dbg_cmd_ready), 32'd0);
            check($sformatf("stall%0d.gpr_wen", i),   32'(gpr_wen), 32'd0);
            @(posedge clk); #1;
        end
        dbg_cmd_valid = 1'b0;
        dbg_rsp_ready = 1'b1;
        @(negedge clk);
        check("stall.handshake_valid", 32'(dbg_rsp_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall.idle_ready", 32'(dbg_cmd_ready), 32'd1);
        check("stall.idle_valid", 32'(dbg_rsp_valid), 32'd0);
        check("stall.idle_data",  dbg_rsp_data, 32'd0);
        @(posedge clk); #1;
        run_vec(100, '{1'b1, 1'b0, 5'd4, 32'h0, 0, 0, 1'b0, 32'hA5A5_0004, 2, 0});

        // ---- reset while a write waits on wb_busy ----
        dbg_cmd_valid  = 1'b1;
        dbg_cmd_write  = 1'b1;
        dbg_cmd_addr   = 5'd12;
        dbg_cmd_wrdata = 32'h1212_1212;
        @(posedge clk); #1;
        dbg_cmd_valid = 1'b0;
        wb_busy       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_l = 1'b0;
        #1;
        check_reset_outputs("rst_write");
        @(posedge clk); #1;
        rst_l    = 1'b1;
        wb_busy  = 1'b0;
        wen_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (gpr_wen) wen_seen = 1'b1;
        end
        check("rst_write.no_wen_after", 32'(wen_seen), 32'd0);
        @(posedge clk); #1;
        run_vec(101, '{1'b1, 1'b0, 5'd12, 32'h0, 0, 0, 1'b0, 32'hA5A5_000C, 2, 0});

        // ---- reset while a response is held ----
        dbg_cmd_valid = 1'b1;
        dbg_cmd_write = 1'b0;
        dbg_cmd_addr  = 5'd3;
        dbg_rsp_ready = 1'b0;
        @(posedge clk); #1;
        dbg_cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp.pre_valid", 32'(dbg_rsp_valid), 32'd1);
        rst_l = 1'b0;
        #1;
        check_reset_outputs("rst_resp");
        @(posedge clk); #1;
        rst_l = 1'b1;
        @(posedge clk); #1;
        run_vec(102, '{1'b1, 1'b1, 5'd13, 32'h1313_1313, 0, 0, 1'b0, 32'h0, 2, 1});
        run_vec(103, '{1'b1, 1'b0, 5'd13, 32'h0, 0, 0, 1'b0, 32'h1313_1313, 2, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
